// File: rtl/pcsfec_rx_llp_buffer.sv
// Receive elastic buffer between the PCS/FEC core and the link layer: link-up gating, show-ahead FIFO, error/overflow stats.
// Optional build macro RXBUF_ERROR_DROP_EN: discard errored beats in RUN instead of forwarding them.
module pcsfec_rx_llp_buffer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3
) (
    input  logic                  clkcore,
    input  logic                  reset_n_core,
    input  logic                  in_enable,
    input  logic [DATA_WIDTH-1:0] phy_llp_data,
    input  logic                  phy_llp_data_valid,
    input  logic                  phy_llp_data_error,
    input  logic                  phy_llp_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_error,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [AW:0]           out_level,
    output logic                  out_overflow,
    output logic [15:0]           out_err_count,
    output logic [15:0]           out_drop_count,
    input  logic                  in_stat_clear
);

    localparam int unsigned CW         = 16;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {ST_DOWN, ST_SYNC, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_link;
    logic                  w_wr_try;
    logic                  w_err_beat;
    logic                  w_flush;
    logic                  w_rd;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_wr_err;
    logic [AW-1:0]         w_rd_ptr_nxt;
    logic [AW:0]           w_level_nxt;
    logic [DATA_WIDTH:0]   w_head;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_error;
    logic                  r_overflow;
    logic [CW-1:0]         r_err_count;
    logic [CW-1:0]         r_drop_count;

    // State register
    always_ff @(posedge clkcore or negedge reset_n_core) begin
        if (!reset_n_core) r_state <= ST_DOWN;
        else               r_state <= w_state_nxt;
    end

    // Next state, write request and error-beat qualification
    always_comb begin
        w_state_nxt = r_state;
        w_wr_try    = 1'b0;
        w_link      = in_enable & phy_llp_ready;
        w_err_beat  = phy_llp_data_valid & phy_llp_data_error & (r_state != ST_DOWN);
        case (r_state)
            ST_DOWN: begin
                if (w_link) w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!w_link) begin
                    w_state_nxt = ST_DOWN;
                end else if (phy_llp_data_valid & ~phy_llp_data_error) begin
                    w_state_nxt = ST_RUN;
                    w_wr_try    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_link) begin
                    w_state_nxt = ST_DOWN;
                end else begin
`ifdef RXBUF_ERROR_DROP_EN
                    w_wr_try = phy_llp_data_valid & ~phy_llp_data_error;
`else
                    w_wr_try = phy_llp_data_valid;
`endif
                end
            end
            default: w_state_nxt = ST_DOWN;
        endcase
    end

`ifdef RXBUF_ERROR_DROP_EN
    assign w_wr_err = 1'b0;
`else
    assign w_wr_err = phy_llp_data_error;
`endif

    // Entering or sitting in DOWN keeps the FIFO empty
    assign w_flush      = (w_state_nxt == ST_DOWN);
    assign w_rd         = r_valid & in_ready;
    assign w_full       = (r_level == FULL_LEVEL);
    assign w_wr         = w_wr_try & (~w_full | w_rd);
    assign w_drop       = w_wr_try & ~w_wr;
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_rd);
    assign w_level_nxt  = r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    // The incoming beat becomes the head directly when it lands in the slot being exposed
    assign w_head       = (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) ? {w_wr_err, phy_llp_data}
                                                              : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clkcore) begin
        if (w_wr) r_mem[r_wr_ptr] <= {w_wr_err, phy_llp_data};
    end

    // Pointers, occupancy and show-ahead head register
    always_ff @(posedge clkcore or negedge reset_n_core) begin
        if (!reset_n_core) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_error  <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_valid  <= (w_level_nxt != '0);
            if (w_level_nxt != '0) begin
                r_error <= w_head[DATA_WIDTH];
                r_data  <= w_head[DATA_WIDTH-1:0];
            end
        end
    end

    // Statistics; clear takes priority over any same-cycle event
    always_ff @(posedge clkcore or negedge reset_n_core) begin
        if (!reset_n_core) begin
            r_overflow   <= 1'b0;
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else if (in_stat_clear) begin
            r_overflow   <= 1'b0;
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_err_beat && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + CW'(1);
            if (w_drop && (r_drop_count != CNT_MAX)) r_drop_count <= r_drop_count + CW'(1);
        end
    end

    assign out_data       = r_data;
    assign out_error      = r_error;
    assign out_valid      = r_valid;
    assign out_level      = r_level;
    assign out_overflow   = r_overflow;
    assign out_err_count  = r_err_count;
    assign out_drop_count = r_drop_count;

endmodule
